// File: rtl/mem_arbiter_19.sv
// mem_arbiter_19 -- arbiter/sequencer for the single-port unified memory of cpu_19.
//
// Shares one memory port between instruction fetch (IF), MEM-stage data
// access (DM) and a loader/debug port (LD). At most one registered memory
// command is issued per cycle. Each read returns a one-cycle rvalid pulse to
// its owner two cycles after the request was sampled.
//
// A small FSM (RUN -> DRAIN -> LOAD) gives the loader exclusive ownership of
// the memory for program preload.
//
// Optional feature: define ARB_STATS_EN to add the saturating statistics
// counters stat_if_cnt, stat_dm_cnt, stat_ld_cnt and stat_conflict_cnt.
//
// Ports:
//   clk1, reset                  clock; synchronous active-low reset
//   if_req/if_addr               fetch request (reads only)
//   if_ack, if_rvalid            fetch command accepted / fetch data on rdata
//   dm_req/dm_we/dm_addr/dm_wdata  data request
//   dm_ack, dm_rvalid            data command accepted / read data on rdata
//   ld_mode                      loader asks for exclusive ownership
//   ld_ready                     loader owns the memory (state LOAD)
//   ld_req/ld_we/ld_addr/ld_wdata  loader request
//   ld_ack, ld_rvalid            loader command accepted / read data on rdata
//   rdata                        shared read data (pass-through of mem_rdata)
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_rdata                    memory read data, valid the cycle after a read
//   arb_state                    0=RUN, 1=DRAIN, 2=LOAD
//   stat_*_cnt                   statistics counters (ARB_STATS_EN only)

module mem_arbiter_19 #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 19,
    parameter int STARVE_LIMIT = 4
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_rvalid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic              dm_rvalid,
    input  logic              ld_mode,
    output logic              ld_ready,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        arb_state
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_if_cnt,
    output logic [CNT_W-1:0]  stat_dm_cnt,
    output logic [CNT_W-1:0]  stat_ld_cnt,
    output logic [CNT_W-1:0]  stat_conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t        state, state_nx;
    logic [SW-1:0] starve_cnt;
    logic          starved;
    logic          grant_if, grant_dm, grant_ld;
    // Read issued in the current cycle; becomes the owner's rvalid next cycle.
    logic          pend_if, pend_dm, pend_ld;

    assign starved   = (starve_cnt == STARVE_MAX);
    assign rdata     = mem_rdata;
    assign arb_state = state;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        grant_if = 1'b0;
        grant_dm = 1'b0;
        grant_ld = 1'b0;
        state_nx = state;
        case (state)
            RUN: begin
                // DM normally wins; a starved IF takes exactly one grant.
                grant_if = if_req && (!dm_req || starved);
                grant_dm = dm_req && !grant_if;
                if (ld_mode) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!ld_mode)                              state_nx = RUN;
                else if (!(pend_if || pend_dm || pend_ld)) state_nx = LOAD;
            end
            LOAD: begin
                // Dropping ld_mode wins over a request sampled in the same cycle.
                if (!ld_mode) state_nx = RUN;
                else          grant_ld = ld_req;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk1) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state      <= RUN;
            starve_cnt <= '0;
            ld_ready   <= 1'b0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            ld_ack     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pend_if    <= 1'b0;
            pend_dm    <= 1'b0;
            pend_ld    <= 1'b0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            ld_rvalid  <= 1'b0;
        end else begin
            state    <= state_nx;
            ld_ready <= (state_nx == LOAD);
            if_ack   <= grant_if;
            dm_ack   <= grant_dm;
            ld_ack   <= grant_ld;
            mem_en   <= grant_if || grant_dm || grant_ld;

            // Address/we/wdata hold when idle; wdata only changes on writes.
            if (grant_dm) begin
                mem_we   <= dm_we;
                mem_addr <= dm_addr;
                if (dm_we) mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end else if (grant_ld) begin
                mem_we   <= ld_we;
                mem_addr <= ld_addr;
                if (ld_we) mem_wdata <= ld_wdata;
            end

            pend_if   <= grant_if;
            pend_dm   <= grant_dm && !dm_we;
            pend_ld   <= grant_ld && !ld_we;
            if_rvalid <= pend_if;
            dm_rvalid <= pend_dm;
            ld_rvalid <= pend_ld;

            // Starvation only accumulates in RUN; outside RUN it stays cleared.
            if (state == RUN && if_req && !grant_if)
                starve_cnt <= starved ? starve_cnt : starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
        end
    end

`ifdef ARB_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Counters step on the edge that raises the matching ack.
    always_ff @(posedge clk1) begin
        if (!reset) begin
            stat_if_cnt       <= '0;
            stat_dm_cnt       <= '0;
            stat_ld_cnt       <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            if (grant_if) stat_if_cnt <= sat_inc(stat_if_cnt);
            if (grant_dm) stat_dm_cnt <= sat_inc(stat_dm_cnt);
            if (grant_ld) stat_ld_cnt <= sat_inc(stat_ld_cnt);
            if (state == RUN && if_req && dm_req)
                stat_conflict_cnt <= sat_inc(stat_conflict_cnt);
        end
    end
`endif

endmodule

// File: doc/mem_arbiter_19.md
Name: mem_arbiter_19

Overview:
Arbiter and sequencer for the single-port 19-bit unified memory of the pipelined cpu_19 core. It shares the memory between three requesters:
- instruction fetch (IF)
- data access from the MEM stage (DM)
- a loader/debug port (LD) for program preload

Each cycle it issues at most one registered memory command and returns a read-valid pulse to the owner of each read. A small FSM gives the loader exclusive ownership for preload.

Parameters:
ADDR_W, 11, memory word-address width
DATA_W, 19, memory word width
STARVE_LIMIT, 4, consecutive denied IF cycles before IF gets one priority grant (>=1)
CNT_W, 16, width of statistics counters (optional feature only)

Ports:
clk1  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
if_req  in  1  fetch request (read only)
if_addr  in  ADDR_W  fetch address
if_ack  out  1  fetch command accepted
if_rvalid  out  1  rdata holds fetch data
dm_req  in  1  data request
dm_we  in  1  1=write, 0=read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_ack  out  1  data command accepted
dm_rvalid  out  1  rdata holds data-read result
ld_mode  in  1  loader requests exclusive ownership
ld_ready  out  1  loader owns memory (state LOAD)
ld_req  in  1  loader request
ld_we  in  1  loader write enable
ld_addr  in  ADDR_W  loader address
ld_wdata  in  DATA_W  loader write data
ld_ack  out  1  loader command accepted
ld_rvalid  out  1  rdata holds loader read result
rdata  out  DATA_W  shared read data, combinational pass-through of mem_rdata
mem_en  out  1  memory command valid
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0
arb_state  out  2  FSM state: 0=RUN, 1=DRAIN, 2=LOAD

Behaviour:
- Reset:
  - all outputs 0, arb_state=RUN, starve_cnt=0
  - any pending rvalid is discarded; no rvalid pulse after reset
- Timing: requests sampled at edge E. The winner's command appears on mem_* and its ack pulses in cycle E+1, both registered. For reads, the matching rvalid pulses in cycle E+2 with rdata=mem_rdata. Writes produce no rvalid.
- Handshake:
  - A requester holds req/addr/we/wdata stable until ack.
  - req still high in the ack cycle counts as a new request, so throughput is 1 access/cycle per requester.
  - ack is one cycle wide.
- mem_en=0 in cycles with no grant. mem_addr, mem_we and mem_wdata hold their previous values when idle.
- RUN:
  - Priority is DM over IF, except when starve_cnt==STARVE_LIMIT; then IF wins that cycle.
  - starve_cnt increments (saturating at STARVE_LIMIT) on each edge where if_req=1 and IF loses.
  - starve_cnt clears on an IF grant or when if_req=0.
  - ld_req is ignored; no ld_ack.
- RUN->DRAIN: ld_mode=1 sampled. From that edge on, no IF/DM grants; the IF/DM command issued in the cycle of the transition still completes.
- DRAIN:
  - Go to LOAD once no read rvalid is pending (1 or 2 cycles).
  - If ld_mode=0 during DRAIN, return to RUN.
- LOAD:
  - ld_ready=1; only LD is granted, with the same timing rules.
  - ld_mode=0 returns to RUN at the next edge; an ld_req in that cycle is ignored.
- Simultaneous if_req, dm_req and ld_mode=1 in RUN: DM (or starved IF) gets the last grant in that same sampling edge, then DRAIN.
- Addresses are used unmodified; there is no wrap logic (the address space is exactly 2^ADDR_W words).

Optional Feature:
Macro ARB_STATS_EN.
- Defined: extra outputs stat_if_cnt, stat_dm_cnt, stat_ld_cnt and stat_conflict_cnt, each CNT_W bits.
  - Each per-requester counter increments on that requester's ack.
  - stat_conflict_cnt increments on each RUN edge where if_req and dm_req are both 1.
  - All counters saturate at all-ones and clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all reqs high -> all outputs 0 and arb_state=0 throughout; first acks appear 1 cycle after reset=1.
- LD preload: ld_mode=1; wait for ld_ready=1; write Mem[0]=0x58005 and Mem[5]=5; read addr 5 -> ld_ack next cycle, ld_rvalid 2 cycles after sampling, rdata=5.
- Single fetch: in RUN, if_req with addr 0 -> mem_en=1, mem_we=0, mem_addr=0 and if_ack in cycle E+1; if_rvalid with rdata=0x58005 in E+2.
- Contention: if_req and dm_req held continuously with STARVE_LIMIT=4 -> grant pattern DM, DM, DM, DM, IF repeating; never two IF grants in a row while dm_req=1.
- Load mid-traffic: ld_mode rises while a DM read is issued -> that dm_rvalid still arrives, arb_state goes 1 then 2, and no if_ack/dm_ack occurs until ld_mode=0.
- Reset mid-read: reset=0 in the cycle between ack and rvalid -> no rvalid pulse; with ARB_STATS_EN defined, all stat counters read 0.
